// File: rtl/decode_stage.sv
// RV32 instruction-decode stage: decodes RV32I (+ optional M/F) into the control
// bundle and holds it in an output register with valid/ready on both sides.
module decode_stage #(
  parameter int SIGNUM    = 35,
  parameter int XLEN      = 32,
  parameter int EN_M      = 1,
  parameter int EN_F      = 0,
  parameter int DIV_EXTRA = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIGNUM-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_instr,
  output logic              md_busy
);

  localparam int CNT_W = (DIV_EXTRA > 0) ? $clog2(DIV_EXTRA + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_EXTRA);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;

  localparam logic [5:0] ALU_SUB  = 6'd0;
  localparam logic [5:0] ALU_ADD  = 6'd1;
  localparam logic [5:0] ALU_AND  = 6'd2;
  localparam logic [5:0] ALU_OR   = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_RMV  = 6'd5;
  localparam logic [5:0] ALU_LMV  = 6'd6;
  localparam logic [5:0] ALU_ARMV = 6'd7;
  localparam logic [5:0] ALU_SLT  = 6'd8;
  localparam logic [5:0] ALU_SLTU = 6'd9;

  localparam logic [3:0] JC_NPC   = 4'd0;
  localparam logic [3:0] JC_OFFPC = 4'd1;
  localparam logic [3:0] JC_NEQ   = 4'd2;
  localparam logic [3:0] JC_EQ    = 4'd3;
  localparam logic [3:0] JC_SLT   = 4'd4;
  localparam logic [3:0] JC_ULT   = 4'd5;
  localparam logic [3:0] JC_SGT   = 4'd6;
  localparam logic [3:0] JC_UGT   = 4'd7;
  localparam logic [3:0] JC_JALR  = 4'd8;

  typedef enum logic [1:0] {IDLE, FULL, MDWAIT} state_t;

  typedef struct packed {
    logic [2:0] sr1mux;
    logic [2:0] sr2mux;
    logic [2:0] rfmux;
    logic       rf_sr1mux;
    logic       rf_sr2mux;
    logic [5:0] alumode;
    logic [2:0] mulmode;
    logic       rfi_we;
    logic       rff_we;
    logic       dm_we;
    logic       dm_rd;
    logic [3:0] jump_ctrl;
    logic       illegal;
  } dec_t;

  function automatic logic [5:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_LMV;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_ARMV : ALU_RMV;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  dec_t       dec;
  logic       dec_div;
  logic [SIGNUM-1:0] dec_ctrl;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    dec     = '0;
    dec_div = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000001) begin
          if (EN_M != 0) begin
            dec.rfmux   = 3'b011;
            dec.mulmode = funct3;
            dec.alumode = ALU_ADD;
            dec.rfi_we  = 1'b1;
            dec_div     = funct3[2];
          end else begin
            dec.illegal = 1'b1;
          end
        end else if (funct7 == 7'b0000000 ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec.alumode = alu_of(funct3, funct7[5]);
          dec.rfi_we  = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_IMM: begin
        dec.sr2mux  = 3'b001;
        dec.rfi_we  = 1'b1;
        dec.alumode = alu_of(funct3, (funct3 == 3'b101) && instruction[30]);
        if (funct3 == 3'b001 && instruction[31:26] != 6'b000000)
          dec.illegal = 1'b1;
        if (funct3 == 3'b101 && instruction[31:26] != 6'b000000 &&
            instruction[31:26] != 6'b010000)
          dec.illegal = 1'b1;
      end
      OP_BRANCH: begin
        dec.alumode = ALU_SUB;
        case (funct3)
          3'b000:  dec.jump_ctrl = JC_EQ;
          3'b001:  dec.jump_ctrl = JC_NEQ;
          3'b100:  dec.jump_ctrl = JC_SLT;
          3'b101:  dec.jump_ctrl = JC_SGT;
          3'b110:  dec.jump_ctrl = JC_ULT;
          3'b111:  dec.jump_ctrl = JC_UGT;
          default: dec.illegal   = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.sr2mux  = 3'b001;
        dec.alumode = ALU_ADD;
        dec.rfmux   = 3'b010;
        dec.dm_rd   = 1'b1;
        dec.rfi_we  = 1'b1;
      end
      OP_STORE: begin
        dec.sr2mux  = 3'b001;
        dec.alumode = ALU_ADD;
        dec.dm_we   = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        dec.sr2mux    = 3'b001;
        dec.alumode   = ALU_ADD;
        dec.rfmux     = 3'b001;
        dec.rfi_we    = 1'b1;
        dec.jump_ctrl = (opcode == OP_JAL) ? JC_OFFPC : JC_JALR;
      end
      OP_AUIPC, OP_LUI: begin
        dec.sr1mux  = (opcode == OP_AUIPC) ? 3'b001 : 3'b010;
        dec.sr2mux  = 3'b001;
        dec.alumode = ALU_ADD;
        dec.rfi_we  = 1'b1;
      end
      OP_FLW: begin
        if (EN_F != 0) begin
          dec.sr2mux  = 3'b001;
          dec.alumode = ALU_ADD;
          dec.rfmux   = 3'b010;
          dec.dm_rd   = 1'b1;
          dec.rff_we  = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_FSW: begin
        if (EN_F != 0) begin
          dec.sr2mux    = 3'b001;
          dec.alumode   = ALU_ADD;
          dec.rf_sr2mux = 1'b1;
          dec.dm_we     = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_FP, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
        if (EN_F != 0) begin
          dec.rfmux     = 3'b100;
          dec.rf_sr1mux = 1'b1;
          dec.rf_sr2mux = 1'b1;
          dec.rff_we    = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase

    // An illegal word must not write anything or redirect the PC; an all-zero word is a bubble.
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      dec_div     = 1'b0;
    end
    if (instruction == 32'h0000_0000) begin
      dec     = '0;
      dec_div = 1'b0;
    end
  end

  always_comb begin
    dec_ctrl        = '0;
    dec_ctrl[2:0]   = dec.sr1mux;
    dec_ctrl[5:3]   = dec.sr2mux;
    dec_ctrl[8:6]   = dec.rfmux;
    dec_ctrl[9]     = dec.rf_sr1mux;
    dec_ctrl[10]    = dec.rf_sr2mux;
    dec_ctrl[19:14] = dec.alumode;
    dec_ctrl[22:20] = dec.mulmode;
    dec_ctrl[24]    = dec.rfi_we;
    dec_ctrl[25]    = dec.rff_we;
    dec_ctrl[27]    = dec.dm_we;
    dec_ctrl[28]    = dec.dm_rd;
    dec_ctrl[33:30] = dec.jump_ctrl;
    dec_ctrl[34]    = dec.illegal;
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;

  assign in_ready  = !flush && (state == IDLE || (state == FULL && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);
  assign md_busy   = (state == MDWAIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, FULL: begin
        if (accept) begin
          if (dec_div && DIV_EXTRA > 0) begin
            state_nxt = MDWAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = FULL;
          end
        end else if (state == FULL && out_ready) begin
          state_nxt = IDLE;
        end
      end
      MDWAIT: begin
        if (cnt == '0) state_nxt = FULL;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: the output data registers are reset so downstream never sees X, even with valid low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_ctrl  <= '0;
      out_pc    <= '0;
      out_instr <= '0;
    end else if (accept) begin
      out_ctrl  <= dec_ctrl;
      out_pc    <= in_pc;
      out_instr <= instruction;
    end
  end

endmodule
